// File: rtl/init_reg_bank.sv
// init_reg_bank: bank of DEPTH registers, WIDTH bits each, all loaded with
// INIT_VAL on asynchronous reset and again by a sequential re-initialisation
// sweep (one entry per cycle, DEPTH cycles in total).
//
// Ports:
//   clk          clock
//   reset        asynchronous, active-high reset
//   wr_valid     write request
//   wr_ready     write port can accept (high only in IDLE)
//   wr_addr      write address
//   wr_data      write data
//   rd_addr      read address
//   rd_data      registered read data (1-cycle latency, INIT_VAL if out of range)
//   reinit_req   start sweep (level, sampled in IDLE)
//   reinit_busy  sweep in progress
//   zero_reject  1-cycle pulse: accepted zero write dropped (ALLOW_ZERO = 0)
//   addr_err     1-cycle pulse: accepted write to wr_addr >= DEPTH dropped
module init_reg_bank #(
    parameter int unsigned      WIDTH      = 4,
    parameter int unsigned      DEPTH      = 8,
    parameter int unsigned      AW         = $clog2(DEPTH),
    parameter logic [WIDTH-1:0] INIT_VAL   = 4'b1101,
    parameter bit               ALLOW_ZERO = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    input  logic             reinit_req,
    output logic             reinit_busy,
    output logic             zero_reject,
    output logic             addr_err
);

    if (!ALLOW_ZERO && (INIT_VAL == '0)) begin : g_bad_init
        $error("init_reg_bank: INIT_VAL must be non-zero when ALLOW_ZERO is 0");
    end
    if (DEPTH < 2) begin : g_bad_depth
        $error("init_reg_bank: DEPTH must be at least 2");
    end

    localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

    typedef enum logic {
        IDLE,
        REINIT
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [WIDTH-1:0]  mem [DEPTH];
    logic [AW-1:0]     ptr;

    logic wr_accept;
    logic wr_in_range;
    logic wr_is_zero;
    logic rd_in_range;

    assign wr_ready    = (state == IDLE);
    assign reinit_busy = (state == REINIT);

    assign wr_accept   = wr_valid && wr_ready;
    assign wr_in_range = ({1'b0, wr_addr} < DEPTH_W);
    assign wr_is_zero  = !ALLOW_ZERO && (wr_data == '0);
    assign rd_in_range = ({1'b0, rd_addr} < DEPTH_W);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (reinit_req) state_next = REINIT;
            REINIT:  if (ptr == LAST) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A write accepted on the same edge as reinit_req lands first; the sweep
    // that starts next cycle overwrites it in due course.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= INIT_VAL;
            end
            ptr         <= '0;
            rd_data     <= INIT_VAL;
            zero_reject <= 1'b0;
            addr_err    <= 1'b0;
        end else begin
            rd_data     <= rd_in_range ? mem[rd_addr] : INIT_VAL;
            zero_reject <= wr_accept && wr_is_zero;
            addr_err    <= wr_accept && !wr_in_range;
            if (wr_accept && wr_in_range && !wr_is_zero) begin
                mem[wr_addr] <= wr_data;
            end
            if (state == REINIT) begin
                mem[ptr] <= INIT_VAL;
                ptr      <= ptr + 1'b1;
            end else begin
                ptr <= '0;
            end
        end
    end

    a_ready_busy_excl: assert property (@(posedge clk) disable iff (reset)
        !(wr_ready && reinit_busy));
    a_zero_pulse: assert property (@(posedge clk) disable iff (reset)
        zero_reject |-> $past(wr_accept));
    a_addr_pulse: assert property (@(posedge clk) disable iff (reset)
        addr_err |-> $past(wr_accept));

    if (!ALLOW_ZERO) begin : g_nonzero
        a_rd_nonzero: assert property (@(posedge clk) disable iff (reset)
            rd_data != '0);
        for (genvar g = 0; g < DEPTH; g++) begin : g_entry
            a_entry_nonzero: assert property (@(posedge clk) disable iff (reset)
                mem[g] != '0);
        end
    end

endmodule

// File: doc/init_reg_bank.md
Name: init_reg_bank

Overview:
- Parametrised bank of DEPTH registers, each WIDTH bits wide.
- Every entry loads a constant INIT_VAL on asynchronous reset, and again on request through a sequential re-initialisation sweep.
- Provides a valid/ready write port and a registered read port.
- Optionally enforces a never-zero invariant on stored contents. This is the generalised successor of the single-register initialised-literal block used in synthesis/SVA test designs.

Parameters:
- WIDTH, 4, bit width of each entry.
- DEPTH, 8, number of entries; need not be a power of 2; must be >= 2.
- AW, $clog2(DEPTH), address width (derived; do not override).
- INIT_VAL, 4'b1101, WIDTH-bit value loaded into every entry on reset and reinit.
- ALLOW_ZERO, 0, 1 = zero data may be stored; 0 = zero writes are rejected.

Ports:
- clk  input  1  clock
- reset  input  1  reset, asynchronous, active-high
- wr_valid  input  1  write request
- wr_ready  output  1  write port can accept
- wr_addr  input  AW  write address
- wr_data  input  WIDTH  write data
- rd_addr  input  AW  read address
- rd_data  output  WIDTH  registered read data
- reinit_req  input  1  start re-initialisation sweep (level, sampled in IDLE)
- reinit_busy  output  1  sweep in progress
- zero_reject  output  1  1-cycle pulse: an accepted write carried zero data and was dropped
- addr_err  output  1  1-cycle pulse: an accepted write had wr_addr >= DEPTH and was dropped

Behaviour:
- Reset (async, any time, including mid-sweep):
  - all entries = INIT_VAL; FSM = IDLE.
  - rd_data = INIT_VAL; zero_reject = 0; addr_err = 0; reinit_busy = 0.
  - wr_ready = 1 once reset is released.
- FSM states IDLE and REINIT.
  - IDLE -> REINIT on a clock edge where reinit_req = 1; sweep pointer = 0.
  - REINIT writes INIT_VAL to entry[ptr] each cycle; ptr increments.
  - After writing entry DEPTH-1, returns to IDLE. The sweep takes exactly DEPTH cycles.
  - reinit_req is ignored while in REINIT.
- wr_ready = (state == IDLE). reinit_busy = (state == REINIT). Both are registered-state decodes with no combinational path from inputs.
- A write is accepted on a clock edge where wr_valid & wr_ready. The entry updates at that edge.
- Same-edge wr_valid and reinit_req in IDLE: the write is accepted and applied, then the sweep starts the next cycle and eventually overwrites that entry with INIT_VAL.
- ALLOW_ZERO = 0 and accepted wr_data == 0: the entry is unchanged and zero_reject = 1 for the following cycle only.
- Accepted wr_addr >= DEPTH: no entry changes and addr_err = 1 for the following cycle only. If both conditions hold, both pulses fire.
- Read path:
  - rd_data <= entry[rd_addr] every cycle (1-cycle latency).
  - rd_addr >= DEPTH returns INIT_VAL.
  - Same-address read and write on the same edge return the old value (read-before-write).
  - Reads remain valid during REINIT and reflect the entries swept so far.
- Invariants (concurrent assertions, disabled during reset):
  - ALLOW_ZERO = 0: no entry is ever 0, and rd_data != 0.
  - ALLOW_ZERO = 0 with INIT_VAL == 0 is an elaboration error.
  - wr_ready and reinit_busy are never both 1.
  - zero_reject and addr_err are never high for 2 consecutive cycles without accepted writes on each preceding edge.

Test Plan:
- Reset release, then read addresses 0..7 -> rd_data = 4'hD each, 1 cycle after each address.
- Write addr 3 = 4'h5, then read 3 -> rd_data = 4'h5. Read 2 -> 4'hD.
- ALLOW_ZERO = 0: write addr 3 = 0 -> handshake completes; zero_reject pulses for 1 cycle; read 3 still returns the prior value.
- Write addr 1 = 4'hA, then assert reinit_req for 1 cycle:
  - reinit_busy is high for exactly 8 cycles with wr_ready low.
  - Afterwards, read 1 returns 4'hD.
  - A wr_valid held during the sweep is accepted on the first IDLE cycle.
- DEPTH = 5: write addr 6 -> addr_err pulses and no entry changes. Read addr 6 -> 4'hD.
- Assert reset mid-sweep at ptr = 4 -> all outputs return to reset values immediately; read of every entry returns INIT_VAL.
